uart_rx_monitor: RTL and testbench

- Synthesizable serial receiver that watches the chip UART transmit line (mprj_io[6]) on the Caravel-based BEC test harness.
- Deframes 8N1 characters and reports each received byte.
- Groups bytes into text lines terminated by line feed (0x0A) so the harness can log firmware progress messages.
- Sits beside the checkbits/id_test GPIO status monitor as a passive observer; it never drives the line.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_baud_tick.sv | 32 +++
 rtl/uart_rx_monitor.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive monitor.
// Optional parity support is built in with UART_RX_PARITY_EN.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Sample-strobe down-counter for the UART receiver.
// Reloaded with a half-bit or full-bit period by the FSM.
module uart_rx_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4167
) (
  input  logic clock,
  input  logic resetb,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic [15:0] cnt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (load_full) begin
      cnt <= FULL;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = (cnt == 16'd0);

endmodule

// File: rtl/uart_rx_monitor.sv
// Passive 8N1 UART receiver with LF-terminated line accounting.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1).
import uart_rx_pkg::*;

module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned MAX_LINE     = 64
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       line_valid,
  output logic [6:0] line_len,
  output logic       busy
);

  logic       s1, s2, s3;
  logic [1:0] fill;
  logic       rx_s, fall;

  state_t     state, state_n;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [6:0] line_cnt;
  logic       tick, load_half, load_full;
  logic       shift, done_ok, done_err;
  logic       par_good;

  // Edges only count once s3 holds a real line sample, so a
  // line held low through reset never looks like a start bit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      {s1, s2, s3} <= 3'b111;
      fill         <= 2'd0;
    end else begin
      s1 <= ser_rx;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  assign rx_s = s2;
  assign fall = (fill == 2'd3) && s3 && !rx_s;

  uart_rx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clock     (clock),
    .resetb    (resetb),
    .load_half (load_half),
    .load_full (load_full),
    .tick      (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_smp, par_ok;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) par_ok <= 1'b0;
    else if (par_smp) par_ok <= (rx_s == ^shreg);
  end

  assign par_good = par_ok;
`else
  assign par_good = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift     = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n   = START;
          load_half = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_n   = DATA;
            load_full = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift     = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_smp   = 1'b1;
          load_full = 1'b1;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          if (rx_s && par_good) done_ok = 1'b1;
          else done_err = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      state <= state_n;
      if (load_half) bit_cnt <= 3'd0;
      else if (shift) bit_cnt <= bit_cnt + 3'd1;
      if (shift) shreg <= {rx_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      line_valid <= 1'b0;
      line_len   <= 7'd0;
      line_cnt   <= 7'd0;
    end else begin
      rx_valid   <= done_ok;
      frame_err  <= done_err;
      line_valid <= done_ok && (shreg == ASCII_LF);
      if (done_ok) begin
        rx_data <= shreg;
        if (shreg == ASCII_LF) begin
          line_len <= line_cnt;
          line_cnt <= 7'd0;
        end else if (shreg != ASCII_CR &&
                     line_cnt < 7'(MAX_LINE)) begin
          line_cnt <= line_cnt + 7'd1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized self-checking bench for uart_rx_monitor.
// Event-level reference model of framing and line accounting.
module tb_uart_rx_monitor;
  import uart_rx_pkg::*;

  localparam int C    = 16;
  localparam int MAXL = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       ser_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, line_valid, busy;
  logic [6:0] line_len;

  always #5 clock = ~clock;

  uart_rx_monitor #(
    .CLKS_PER_BIT(C),
    .MAX_LINE    (MAXL)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .ser_rx     (ser_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .line_valid (line_valid),
    .line_len   (line_len),
    .busy       (busy)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         lv;
    logic [6:0] len;
  } ev_t;

  ev_t        obs[$];
  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         mcnt = 0;
  logic [7:0] last_good = 8'd0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetb && (rx_valid || frame_err)) begin
      check("excl", 32'(rx_valid & frame_err), 32'd0);
      obs.push_back('{err: frame_err, data: rx_data,
                      lv: line_valid,
                      len: line_valid ? line_len : 7'd0});
    end
  end

  task automatic model_frame(input logic [7:0] b,
                             input bit stop_bit,
                             input bit pflip);
    bit ok;
    ok = stop_bit && !(PAR && pflip);
    if (!ok) begin
      exp_q.push_back('{err: 1'b1, data: last_good,
                        lv: 1'b0, len: 7'd0});
    end else begin
      last_good = b;
      if (b == ASCII_LF) begin
        exp_q.push_back('{err: 1'b0, data: b, lv: 1'b1,
                          len: 7'(mcnt)});
        mcnt = 0;
      end else begin
        exp_q.push_back('{err: 1'b0, data: b, lv: 1'b0,
                          len: 7'd0});
        if (b != ASCII_CR && mcnt < MAXL) mcnt++;
      end
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input bit stop_bit,
                      input bit pflip);
    model_frame(b, stop_bit, pflip);
    ser_rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (C) @(negedge clock);
    end
    if (PAR) begin
      ser_rx = (^b) ^ pflip;
      repeat (C) @(negedge clock);
    end
    ser_rx = stop_bit;
    repeat (C) @(negedge clock);
    ser_rx = 1'b1;
    repeat ($urandom_range(2, C)) @(negedge clock);
  endtask

  task automatic compare(input string tag);
    ev_t o, e;
    repeat (2 * C) @(negedge clock);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      check({tag, "_err"}, 32'(o.err), 32'(e.err));
      check({tag, "_data"}, 32'(o.data), 32'(e.data));
      check({tag, "_lv"}, 32'(o.lv), 32'(e.lv));
      check({tag, "_len"}, 32'(o.len), 32'(e.len));
    end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic hit_reset(input string tag);
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    check({tag, "_rst_out"},
          {19'd0, rx_data, rx_valid, frame_err,
           line_valid, line_len, busy}, 32'd0);
    resetb = 1'b1;
    mcnt = 0;
    last_good = 8'd0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] txt [4];
    int r;

    ser_rx = 1'b1;
    hit_reset("init");
    repeat (20 * C) @(negedge clock);
    check("idle_data", 32'(rx_data), 32'd0);
    compare("idle");

    send(8'h41, 1'b1, 1'b0);
    compare("A");

    txt[0] = 8'h4C; txt[1] = 8'h41;
    txt[2] = ASCII_CR; txt[3] = ASCII_LF;
    for (int i = 0; i < 4; i++) send(txt[i], 1'b1, 1'b0);
    compare("LA_crlf");

    send(8'h55, 1'b0, 1'b0);
    compare("stop_err");
    send(8'h5A, 1'b1, 1'b0);
    send(ASCII_LF, 1'b1, 1'b0);
    compare("after_err");

    ser_rx = 1'b0;
    repeat (C / 4) @(negedge clock);
    ser_rx = 1'b1;
    repeat (2 * C) @(negedge clock);
    check("glitch_busy", 32'(busy), 32'd0);
    send(8'h30, 1'b1, 1'b0);
    compare("glitch");

    b = 8'hA5;
    ser_rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      ser_rx = b[i];
      repeat (C) @(negedge clock);
    end
    ser_rx = 1'b1;
    hit_reset("mid");
    repeat (2 * C) @(negedge clock);
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1);
    compare("mid_reset");

    ser_rx = 1'b0;
    hit_reset("low");
    repeat (3 * C) @(negedge clock);
    check("low_busy", 32'(busy), 32'd0);
    ser_rx = 1'b1;
    repeat (2 * C) @(negedge clock);
    compare("low_reset");

    for (int i = 0; i < 70; i++) send(8'h78, 1'b1, 1'b0);
    send(ASCII_LF, 1'b1, 1'b0);
    compare("saturate");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) b = ASCII_LF;
        else if (r == 1) b = ASCII_CR;
        else b = 8'($urandom);
        send(b, $urandom_range(0, 7) != 0,
             $urandom_range(0, 7) == 0);
      end
      compare("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
